sync_fifo_gen2: RTL and testbench
=================================

SYNC_FIFO_GEN2 -- requirements
Module: sync_fifo_gen2

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 16: number of entries, a power of two, legal range 2..256.
REQ-003 SHALL have parameter AFULL_THR, default DEPTH-2: almost_full asserts when count >= AFULL_THR.
REQ-004 SHALL have parameter AEMPTY_THR, default 2: almost_empty asserts when count <= AEMPTY_THR.
REQ-005 SHALL have parameter FWFT, default 0: 0 selects registered read, 1 selects first-word-fall-through.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port wr_data, input, WIDTH bits: write word.
REQ-010 SHALL have port rd_en, input, 1 bit: read request; in FWFT mode it is the pop/acknowledge of the head word.
REQ-011 SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-012 SHALL have port rd_data, output, WIDTH bits: read word.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data holds a valid word.
REQ-014 SHALL have ports full, empty, almost_full and almost_empty, each an output of 1 bit: occupancy flags.
REQ-015 SHALL have port count, output, log2(DEPTH)+1 bits: current number of stored entries, range 0..DEPTH.
REQ-016 SHALL have ports overflow and underflow, each an output of 1 bit: sticky error flags.

Function
REQ-017 SHALL accept a write iff wr_en=1 and full=0; an accepted write stores wr_data at the write pointer, and the write pointer increments modulo DEPTH.
REQ-018 SHALL accept a read iff rd_en=1 and empty=0; an accepted read increments the read pointer modulo DEPTH.
REQ-019 SHALL evaluate full and empty from registered state only, so a write while full is rejected even if a read is accepted in the same cycle, and a read while empty is rejected even if a write is accepted in the same cycle.
REQ-020 SHALL update count by +1 for a write only, -1 for a read only, and 0 for both or neither; count never exceeds DEPTH and never underflows below 0.
REQ-021 SHALL drive full = (count==DEPTH), empty = (count==0), almost_full = (count>=AFULL_THR) and almost_empty = (count<=AEMPTY_THR), all reflecting the registered count.
REQ-022 SHALL use pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0 with no loss of data or ordering.
REQ-023 SHALL, with FWFT=0, load rd_data with the head word on the edge that accepts a read, pulse rd_valid high for exactly that following cycle, and otherwise hold rd_data at its last value.
REQ-024 SHALL, with FWFT=1, present the head word on rd_data whenever empty=0 with rd_valid=!empty; an accepted read advances rd_data to the next word on the following edge.
REQ-025 SHALL, in FWFT mode, make a word written into an empty FIFO appear on rd_data with rd_valid=1 in the cycle after the write edge.
REQ-026 SHALL set overflow on any edge where wr_en=1 and full=1, and set underflow on any edge where rd_en=1 and empty=1; both flags stay set until clr_err.
REQ-027 SHALL, when clr_err=1 on an edge, clear both error flags, except that a new error on that same edge sets its flag (set wins).
REQ-028 SHALL leave storage contents unchanged on rejected writes, and leave pointers and count unchanged on rejected operations.

Reset
REQ-029 SHALL, on rst=1 and asynchronously, force both pointers to 0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0 and underflow=0.
REQ-030 SHALL, on reset asserted mid-operation, discard all stored entries; storage array contents need no reset.
REQ-031 SHALL accept the first write on the first rising edge after rst deasserts.

Verification
REQ-032 SHALL cover fill then drain at DEPTH=4, FWFT=0: write 0x11,0x22,0x33,0x44 -> full=1, count=4; then 4 reads -> rd_data 0x11..0x44 each with a one-cycle rd_valid pulse, ending with empty=1.
REQ-033 SHALL cover overflow and clear: a 5th write when full -> overflow=1, count remains 4, and later data is unchanged; then clr_err=1 -> overflow=0.
REQ-034 SHALL cover simultaneous read and write at count=2 -> count stays 2, with order preserved across pointer wrap over 3 fill/drain cycles.
REQ-035 SHALL cover FWFT=1: write 0xA5 into the empty FIFO -> next cycle rd_valid=1 and rd_data=0xA5 without any rd_en; then rd_en=1 -> empty=1 and rd_valid=0.
REQ-036 SHALL cover thresholds at DEPTH=16 with defaults: count 13 -> almost_full=0; count 14 -> almost_full=1; count 3 -> almost_empty=0; count 2 -> almost_empty=1.
REQ-037 SHALL cover async reset at count=3, asserted between edges -> all outputs take their reset values immediately, and the read after refill returns only the new data.

Source files
------------

// File: rtl/sync_fifo_gen2.sv
// sync_fifo_gen2
// Single-clock FIFO with occupancy flags and sticky error flags. It has two read modes:
//   FWFT=0 : registered read. rd_data loads on the accepting edge, and rd_valid
//            pulses for one cycle.
//   FWFT=1 : first-word-fall-through. The head word is always visible while the
//            FIFO is non-empty, and rd_en pops it.
//
// Parameters
//   WIDTH      data word width (1..32)
//   DEPTH      number of entries, power of two (2..256)
//   AFULL_THR  almost_full  when count >= AFULL_THR
//   AEMPTY_THR almost_empty when count <= AEMPTY_THR
//   FWFT       read mode select
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   wr_en, wr_data             write request and word
//   rd_en                      read request / pop
//   clr_err                    clears overflow/underflow (a new error on the same edge wins)
//   rd_data, rd_valid          read word and its qualifier
//   full, empty                occupancy flags from the registered count
//   almost_full, almost_empty  threshold flags from the registered count
//   count                      stored entries, 0..DEPTH
//   overflow, underflow        sticky error flags
module sync_fifo_gen2 #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2,
    parameter int FWFT       = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             ovf_q;
    logic             udf_q;

    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;

    // The flags come only from the registered count. A simultaneous read
    // therefore never makes room for a write in the same cycle, and a
    // simultaneous write never feeds a read in the same cycle.
    assign full_w  = (cnt == CW'(DEPTH));
    assign empty_w = (cnt == '0);
    assign wr_acc  = wr_en & ~full_w;
    assign rd_acc  = rd_en & ~empty_w;

    // Storage has no reset. Entries are invalidated by resetting the pointers
    // and the count.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            // A clear drops the old state, but an error on the same edge still sets the flag.
            ovf_q <= (ovf_q & ~clr_err) | (wr_en & full_w);
            udf_q <= (udf_q & ~clr_err) | (rd_en & empty_w);
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is read combinationally. A word written into an empty FIFO
        // is visible one cycle after its write edge, once the count has gone to 1.
        assign rd_data  = empty_w ? '0 : mem[rd_ptr];
        assign rd_valid = ~empty_w;
    end else begin : g_reg
        logic [WIDTH-1:0] rd_data_p1;
        logic             vld_p1;

        // ---- read stage: head word captured on the accepting edge ----
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_data_p1 <= '0;
                vld_p1     <= 1'b0;
            end else begin
                vld_p1 <= rd_acc;
                if (rd_acc) begin
                    rd_data_p1 <= mem[rd_ptr];
                end
            end
        end

        assign rd_data  = rd_data_p1;
        assign rd_valid = vld_p1;
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (int'(cnt) >= AFULL_THR);
    assign almost_empty = (int'(cnt) <= AEMPTY_THR);
    assign count        = cnt;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_gen2.sv
module tb_sync_fifo_gen2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // DUT a: DEPTH=4, registered read
    logic       a_wr, a_rd, a_clr;
    logic [7:0] a_wd, a_rdata;
    logic       a_rdv, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_cnt;
    // DUT b: DEPTH=4, FWFT
    logic       b_wr, b_rd, b_clr;
    logic [7:0] b_wd, b_rdata;
    logic       b_rdv, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [2:0] b_cnt;
    // DUT c: DEPTH=16, default thresholds, registered read
    logic       c_wr, c_rd, c_clr;
    logic [7:0] c_wd, c_rdata;
    logic       c_rdv, c_full, c_empty, c_af, c_ae, c_ovf, c_udf;
    logic [4:0] c_cnt;

    sync_fifo_gen2 #(.WIDTH(8), .DEPTH(4), .FWFT(0)) u_a (
        .clk(clk), .rst(rst), .wr_en(a_wr), .wr_data(a_wd), .rd_en(a_rd), .clr_err(a_clr),
        .rd_data(a_rdata), .rd_valid(a_rdv), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_gen2 #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_b (
        .clk(clk), .rst(rst), .wr_en(b_wr), .wr_data(b_wd), .rd_en(b_rd), .clr_err(b_clr),
        .rd_data(b_rdata), .rd_valid(b_rdv), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
        .overflow(b_ovf), .underflow(b_udf));

    sync_fifo_gen2 #(.WIDTH(8), .DEPTH(16)) u_c (
        .clk(clk), .rst(rst), .wr_en(c_wr), .wr_data(c_wd), .rd_en(c_rd), .clr_err(c_clr),
        .rd_data(c_rdata), .rd_valid(c_rdv), .full(c_full), .empty(c_empty),
        .almost_full(c_af), .almost_empty(c_ae), .count(c_cnt),
        .overflow(c_ovf), .underflow(c_udf));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change at the falling edge and outputs are checked at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       clr;
        int         cnt;
        logic       full;
        logic       empty;
        logic       rdv;
        logic [7:0] rdata;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vt [29];
    logic [7:0] q [$];

    initial begin
        //        wr    wd     rd    clr   cnt full  empty rdv   rdata  ovf   udf
        vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 8'h55, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
        vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
        vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0};
        vt[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1};
        vt[13] = '{1'b1, 8'h66, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1};
        vt[14] = '{1'b1, 8'h77, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0};
        vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b1};
        vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[18] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[19] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[20] = '{1'b1, 8'hA3, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[21] = '{1'b1, 8'hA4, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
        vt[22] = '{1'b1, 8'hB5, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0};
        vt[23] = '{1'b0, 8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0};
        vt[24] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0};
        vt[25] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        vt[26] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b0, 1'b0};
        vt[27] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b1};
        vt[28] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b0};

        rst = 1'b1;
        {a_wr, a_rd, a_clr, a_wd} = '0;
        {b_wr, b_rd, b_clr, b_wd} = '0;
        {c_wr, c_rd, c_clr, c_wd} = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_a_cnt", 32'(a_cnt), 0);
        chk("rst_a_empty", 32'(a_empty), 1);
        chk("rst_a_ae", 32'(a_ae), 1);
        chk("rst_a_full", 32'(a_full), 0);
        chk("rst_a_af", 32'(a_af), 0);
        chk("rst_a_rdv", 32'(a_rdv), 0);
        chk("rst_a_rdata", 32'(a_rdata), 0);
        chk("rst_a_ovf", 32'(a_ovf), 0);
        chk("rst_a_udf", 32'(a_udf), 0);
        chk("rst_b_rdv", 32'(b_rdv), 0);
        chk("rst_c_cnt", 32'(c_cnt), 0);
        rst = 1'b0;

        // Fill/drain, overflow/underflow and clear (DEPTH=4, AFULL=2, AEMPTY=2)
        for (int i = 0; i < 29; i++) begin
            a_wr = vt[i].wr; a_wd = vt[i].wd; a_rd = vt[i].rd; a_clr = vt[i].clr;
            step();
            chk($sformatf("v%0d_cnt", i), 32'(a_cnt), 32'(vt[i].cnt));
            chk($sformatf("v%0d_full", i), 32'(a_full), 32'(vt[i].full));
            chk($sformatf("v%0d_empty", i), 32'(a_empty), 32'(vt[i].empty));
            chk($sformatf("v%0d_af", i), 32'(a_af), 32'(vt[i].cnt >= 2));
            chk($sformatf("v%0d_ae", i), 32'(a_ae), 32'(vt[i].cnt <= 2));
            chk($sformatf("v%0d_rdv", i), 32'(a_rdv), 32'(vt[i].rdv));
            chk($sformatf("v%0d_rdata", i), 32'(a_rdata), 32'(vt[i].rdata));
            chk($sformatf("v%0d_ovf", i), 32'(a_ovf), 32'(vt[i].ovf));
            chk($sformatf("v%0d_udf", i), 32'(a_udf), 32'(vt[i].udf));
        end
        {a_wr, a_rd, a_clr} = '0;

        // Simultaneous read/write at count 2 across pointer wrap, three rounds
        for (int it = 0; it < 3; it++) begin
            for (int k = 0; k < 2; k++) begin
                a_wr = 1'b1; a_wd = 8'(it * 16 + k); q.push_back(a_wd);
                step();
            end
            for (int k = 2; k < 6; k++) begin
                logic [7:0] exp;
                a_wr = 1'b1; a_rd = 1'b1; a_wd = 8'(it * 16 + k);
                exp = q.pop_front(); q.push_back(a_wd);
                step();
                chk($sformatf("sim%0d_%0d_cnt", it, k), 32'(a_cnt), 2);
                chk($sformatf("sim%0d_%0d_rdata", it, k), 32'(a_rdata), 32'(exp));
            end
            a_wr = 1'b0;
            for (int k = 0; k < 2; k++) begin
                logic [7:0] exp;
                a_rd = 1'b1; exp = q.pop_front();
                step();
                chk($sformatf("drn%0d_%0d_rdata", it, k), 32'(a_rdata), 32'(exp));
                chk($sformatf("drn%0d_%0d_rdv", it, k), 32'(a_rdv), 1);
            end
            a_rd = 1'b0;
            chk($sformatf("drn%0d_empty", it), 32'(a_empty), 1);
        end

        // FWFT: a word fall-through without rd_en, then pops
        b_wr = 1'b1; b_wd = 8'hA5;
        step();
        b_wr = 1'b0;
        chk("fwft_rdv", 32'(b_rdv), 1);
        chk("fwft_rdata", 32'(b_rdata), 32'h A5);
        chk("fwft_empty", 32'(b_empty), 0);
        step();
        chk("fwft_hold", 32'(b_rdata), 32'h A5);
        chk("fwft_cnt_hold", 32'(b_cnt), 1);
        b_rd = 1'b1;
        step();
        b_rd = 1'b0;
        chk("fwft_pop_empty", 32'(b_empty), 1);
        chk("fwft_pop_rdv", 32'(b_rdv), 0);
        b_wr = 1'b1; b_wd = 8'h3C; step();
        b_wd = 8'h4D; step();
        b_wr = 1'b0;
        chk("fwft_head", 32'(b_rdata), 32'h3C);
        b_rd = 1'b1; step();
        chk("fwft_next", 32'(b_rdata), 32'h4D);
        chk("fwft_next_rdv", 32'(b_rdv), 1);
        step();
        b_rd = 1'b0;
        chk("fwft_drain_rdv", 32'(b_rdv), 0);
        chk("fwft_drain_udf", 32'(b_udf), 0);

        // Thresholds at DEPTH=16 with default parameters
        for (int i = 0; i < 13; i++) begin
            c_wr = 1'b1; c_wd = 8'(i); step();
        end
        c_wr = 1'b0;
        chk("thr_cnt13", 32'(c_cnt), 13);
        chk("thr_af13", 32'(c_af), 0);
        c_wr = 1'b1; c_wd = 8'd13; step();
        c_wr = 1'b0;
        chk("thr_af14", 32'(c_af), 1);
        chk("thr_full14", 32'(c_full), 0);
        for (int i = 0; i < 11; i++) begin
            c_rd = 1'b1; step();
        end
        c_rd = 1'b0;
        chk("thr_cnt3", 32'(c_cnt), 3);
        chk("thr_ae3", 32'(c_ae), 0);
        chk("thr_af3", 32'(c_af), 0);
        c_rd = 1'b1; step();
        c_rd = 1'b0;
        chk("thr_ae2", 32'(c_ae), 1);
        chk("thr_rdata11", 32'(c_rdata), 11);

        // Async reset between edges with three entries stored
        a_wr = 1'b1;
        a_wd = 8'hC1; step();
        a_wd = 8'hC2; step();
        a_wd = 8'hC3; step();
        a_wr = 1'b0;
        chk("ar_cnt3", 32'(a_cnt), 3);
        #2 rst = 1'b1;
        #1;
        chk("ar_cnt", 32'(a_cnt), 0);
        chk("ar_empty", 32'(a_empty), 1);
        chk("ar_ae", 32'(a_ae), 1);
        chk("ar_full", 32'(a_full), 0);
        chk("ar_af", 32'(a_af), 0);
        chk("ar_rdv", 32'(a_rdv), 0);
        chk("ar_rdata", 32'(a_rdata), 0);
        chk("ar_ovf", 32'(a_ovf), 0);
        chk("ar_udf", 32'(a_udf), 0);
        chk("ar_c_cnt", 32'(c_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        a_wr = 1'b1; a_wd = 8'hD1;
        step();
        a_wr = 1'b0;
        chk("ar_first_wr_cnt", 32'(a_cnt), 1);
        a_rd = 1'b1;
        step();
        a_rd = 1'b0;
        chk("ar_new_rdata", 32'(a_rdata), 32'h D1);
        chk("ar_new_empty", 32'(a_empty), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
